// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants shared by the sync generator and the
// renderer, plus a small range helper for the sync windows.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;    // 100 MHz board clock -> 25 MHz pixel rate
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;  // 525

  // Sync pulses cover [START, END) in counter coordinates
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;               // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;             // 752
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;               // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;             // 492

  // True when lo <= v < hi
  function automatic logic in_span(input logic [9:0] v, input int lo, input int hi);
    return (v >= 10'(lo)) && (v < 10'(hi));
  endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo-N counter with enable. wrap is combinational so several instances
// can be chained into a single-edge carry chain (divider -> x -> y).
module mod_counter #(
  parameter int N     = 4,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == WIDTH'(N - 1));

  // Advance on enable, returning to zero after N-1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the board clock to the pixel rate, runs the
// x/y raster counters, and re-times the renderer colour together with
// hsync/vsync so all connector pins change on the same clock edge, one pixel
// period behind the counters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = vga_timing_pkg::CLK_DIV,
  parameter int   H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK      = vga_timing_pkg::H_BACK,
  parameter int   V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK      = vga_timing_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] objRed,
  input  logic [3:0] objGreen,
  input  logic [3:0] objBlue,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY,
  output logic       pixel_tick,
  output logic       video_on,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // The counters are 10 bits wide, and the colour needs a settle clock
  // before it is sampled, so the divider must be at least 2.
  if (H_TOTAL > 1024) begin : g_h_total_too_big
    $error("vga_sync_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_too_big
    $error("vga_sync_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 2) begin : g_clk_div_too_small
    $error("vga_sync_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic             h_wrap;
  logic             v_wrap;

  mod_counter #(.N(CLK_DIV), .WIDTH(DIV_W)) u_div (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .count (div),
    .wrap  (div_wrap)
  );

  mod_counter #(.N(H_TOTAL), .WIDTH(10)) u_h (
    .clock (clock),
    .reset (reset),
    .en    (div_wrap),
    .count (pixelX),
    .wrap  (h_wrap)
  );

  mod_counter #(.N(V_TOTAL), .WIDTH(10)) u_v (
    .clock (clock),
    .reset (reset),
    .en    (h_wrap),
    .count (pixelY),
    .wrap  (v_wrap)
  );

  // Last clock of the last pixel of the frame: the edge that ends it wraps both counters
  assign frame_tick = v_wrap;
  assign video_on   = (pixelX < 10'(H_DISPLAY)) && (pixelY < 10'(V_DISPLAY));

  // Registered one clock early so pixel_tick is high exactly while div == CLK_DIV-1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_tick <= 1'b0;
    end else begin
      pixel_tick <= (div == DIV_W'(CLK_DIV - 2));
    end
  end

  // Connector stage: colour and syncs for the pixel just finished, loaded together
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync    <= ~SYNC_ACTIVE;
      vsync    <= ~SYNC_ACTIVE;
      vgaRed   <= 4'h0;
      vgaGreen <= 4'h0;
      vgaBlue  <= 4'h0;
    end else if (div_wrap) begin
      hsync    <= in_span(pixelX, H_SYNC_START, H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync    <= in_span(pixelY, V_SYNC_START, V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vgaRed   <= video_on ? objRed   : 4'h0;
      vgaGreen <= video_on ? objGreen : 4'h0;
      vgaBlue  <= video_on ? objBlue  : 4'h0;
    end
  end

endmodule
